// File: rtl/cycloneiiils_pll_phase_ctrl_pkg.sv
// Purpose: shared types for the PLL dynamic phase-shift sequencer (state encoding, counter selects).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cycloneiiils_pll_pkg;

  localparam int CNT_SEL_W_DEF = 3;

  // Sequencer states; IDLE is the only state that accepts a request.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STEP,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_FINISH,
    ST_ABORT
  } state_t;

  // phasecountersel encodings understood by the Cyclone III LS PLL atom.
  typedef enum logic [CNT_SEL_W_DEF-1:0] {
    CSEL_ALL = 3'd0,
    CSEL_M   = 3'd1,
    CSEL_C0  = 3'd2,
    CSEL_C1  = 3'd3,
    CSEL_C2  = 3'd4,
    CSEL_C3  = 3'd5,
    CSEL_C4  = 3'd6
  } csel_t;

endpackage

// File: rtl/cycloneiiils_pll_phase_ctrl_if.sv
// Purpose: request channel (valid/ready plus counter select, direction, step count).
// Latency: n/a (wiring only).
// Backpressure: slave drives req_ready; a transfer happens on req_valid && req_ready.
interface cycloneiiils_pll_phase_ctrl_if
  import cycloneiiils_pll_pkg::*;
#(
  parameter int CNT_SEL_W = CNT_SEL_W_DEF,
  parameter int STEP_W    = 8
);

  logic                 req_valid;
  logic                 req_ready;
  logic [CNT_SEL_W-1:0] req_cntsel;
  logic                 req_updown;
  logic [STEP_W-1:0]    req_steps;

  modport master (
    output req_valid,
    output req_cntsel,
    output req_updown,
    output req_steps,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_cntsel,
    input  req_updown,
    input  req_steps,
    output req_ready
  );

endinterface

// File: rtl/cycloneiiils_pll_phase_ctrl_timer.sv
// Purpose: loadable down-counter that saturates at zero; zero_o flags expiry.
// Latency: load takes effect on the next clock; zero_o is a registered-count compare.
// Backpressure: none; en_i simply pauses the count.
module cycloneiiils_pll_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over counting; the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cycloneiiils_pll_phase_ctrl.sv
// Purpose: sequences PLL dynamic phase steps (phasestep/phaseupdown/phasecountersel) with phasedone handshake.
// Latency: transfer at cycle T -> phasestep at T+2; each step = 1 + PULSE_CYC + phasedone wait cycles.
// Backpressure: req_ready only in IDLE; optional wait timeout via CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN.
module cycloneiiils_pll_phase_ctrl
  import cycloneiiils_pll_pkg::*;
#(
  parameter int CNT_SEL_W   = CNT_SEL_W_DEF,
  parameter int STEP_W      = 8,
  parameter int PULSE_CYC   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  cycloneiiils_pll_phase_ctrl_if.slave req,
  input  logic                         pll_locked,
  input  logic                         pll_phasedone,
  output logic                         phasestep,
  output logic                         phaseupdown,
  output logic [CNT_SEL_W-1:0]         phasecountersel,
  output logic                         busy,
  output logic                         done,
  output logic                         err
`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
  ,
  output logic                         timeout_err
`endif
);

  // Reject nonsensical configurations at elaboration.
  if ((PULSE_CYC < 1) || (TIMEOUT_CYC < 1)) begin : g_param_chk
    $error("PULSE_CYC and TIMEOUT_CYC must both be >= 1");
  end

  localparam int PW = $clog2(PULSE_CYC + 1);

  state_t               state_q, state_d;
  logic [STEP_W-1:0]    rem_q, rem_d;
  logic [STEP_W-1:0]    rem_dec;
  logic [CNT_SEL_W-1:0] sel_q, sel_d;
  logic                 ud_q, ud_d;
  logic                 err_q, err_d;
  logic                 xfer;
  logic                 pulse_load, pulse_en, pulse_zero;

  assign req.req_ready = (state_q == ST_IDLE);
  assign xfer          = req.req_valid && (state_q == ST_IDLE);

  // Strobe-width timer: loaded with PULSE_CYC-1 on entry to STEP, expires on the last strobe cycle.
  cycloneiiils_pll_phase_timer #(.W(PW)) u_pulse_tmr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (pulse_load),
    .load_val_i (PW'(PULSE_CYC - 1)),
    .en_i       (pulse_en),
    .zero_o     (pulse_zero)
  );

`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic tmo_load, tmo_en, tmo_zero;
  logic tmo_q, tmo_d;

  // Per-wait watchdog: reloaded on entry to WAIT_LO and WAIT_HI, expires after TIMEOUT_CYC cycles there.
  cycloneiiils_pll_phase_timer #(.W(TW)) u_tmo_tmr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmo_load),
    .load_val_i (TW'(TIMEOUT_CYC - 1)),
    .en_i       (tmo_en),
    .zero_o     (tmo_zero)
  );
`endif

  // Next-state and datapath control; lock loss is checked before phasedone progress.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    rem_dec    = rem_q;
    sel_d      = sel_q;
    ud_d       = ud_q;
    err_d      = err_q;
    pulse_load = 1'b0;
    pulse_en   = 1'b0;
`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
    tmo_d      = tmo_q;
    tmo_load   = 1'b0;
    tmo_en     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          err_d = 1'b0;
`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
          tmo_d = 1'b0;
`endif
          rem_d = req.req_steps;
          if (req.req_steps == '0) begin
            state_d = ST_FINISH;
          end else if (!pll_locked) begin
            state_d = ST_ABORT;
          end else begin
            // Select/direction change on the edge into SETUP so the PLL sees them during SETUP.
            state_d = ST_SETUP;
            sel_d   = req.req_cntsel;
            ud_d    = req.req_updown;
          end
        end
      end
      ST_SETUP: begin
        if (!pll_locked) begin
          state_d = ST_ABORT;
        end else begin
          state_d    = ST_STEP;
          pulse_load = 1'b1;
        end
      end
      ST_STEP: begin
        pulse_en = 1'b1;
        if (!pll_locked) begin
          state_d = ST_ABORT;
        end else if (pulse_zero) begin
          state_d = ST_WAIT_LO;
`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
          tmo_load = 1'b1;
`endif
        end
      end
      ST_WAIT_LO: begin
`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
        tmo_en = 1'b1;
`endif
        if (!pll_locked) begin
          state_d = ST_ABORT;
        end else if (!pll_phasedone) begin
          state_d = ST_WAIT_HI;
`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
          tmo_load = 1'b1;
        end else if (tmo_zero) begin
          state_d = ST_ABORT;
          tmo_d   = 1'b1;
`endif
        end
      end
      ST_WAIT_HI: begin
`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
        tmo_en = 1'b1;
`endif
        if (!pll_locked) begin
          state_d = ST_ABORT;
        end else if (pll_phasedone) begin
          if (rem_q != '0) begin
            rem_dec = rem_q - 1'b1;
          end
          rem_d   = rem_dec;
          state_d = (rem_dec == '0) ? ST_FINISH : ST_SETUP;
`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
        end else if (tmo_zero) begin
          state_d = ST_ABORT;
          tmo_d   = 1'b1;
`endif
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ABORT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Any route into ABORT discards the remaining steps and raises the sticky flag.
    if (state_d == ST_ABORT) begin
      err_d = 1'b1;
      rem_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      sel_q   <= '0;
      ud_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      ud_q    <= ud_d;
      err_q   <= err_d;
    end
  end

`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
  // Sticky timeout flag, cleared like err.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`endif

  // phasestep drops in the very cycle lock is seen low, not one cycle later.
  assign phasestep       = (state_q == ST_STEP) && pll_locked;
  assign phaseupdown     = ud_q;
  assign phasecountersel = sel_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_FINISH) || (state_q == ST_ABORT);
  assign err             = err_q;

endmodule

// File: tb/tb_cycloneiiils_pll_phase_ctrl.sv
// Purpose: randomized scoreboard bench for the PLL phase-shift sequencer, with a phasedone PLL model.
// Latency: checks first strobe at T+2, zero-step/at-accept-abort done at T+1, timeout abort timing.
// Backpressure: holds req_valid with changing fields while busy; timeout case under CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN.
module tb_cycloneiiils_pll_phase_ctrl;
  import cycloneiiils_pll_pkg::*;

  localparam int PULSE = 2;
  localparam int TMO   = 16;
  localparam int NREQ  = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b1;
  logic       pll_phasedone = 1'b1;
  logic       phasestep, phaseupdown, busy, done, err;
  logic [2:0] phasecountersel;
`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
  logic       timeout_err;
`endif

  cycloneiiils_pll_phase_ctrl_if #(.CNT_SEL_W(3), .STEP_W(8)) rif ();

  cycloneiiils_pll_phase_ctrl #(
    .CNT_SEL_W(3), .STEP_W(8), .PULSE_CYC(PULSE), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (rif),
    .pll_locked      (pll_locked),
    .pll_phasedone   (pll_phasedone),
    .phasestep       (phasestep),
    .phaseupdown     (phaseupdown),
    .phasecountersel (phasecountersel),
    .busy            (busy),
    .done            (done),
    .err             (err)
`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
    ,
    .timeout_err     (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // kind 0 = one phasestep pulse, kind 1 = end of request (done)
  typedef struct {
    int kind;
    int sel;
    int ud;
    int err;
    int tmo;
    int cyc;
  } exp_t;
  exp_t sb[$];

  bit mon_en   = 1'b0;
  bit pll_idle = 1'b1;
  bit pd_off   = 1'b0;
  bit abort_run = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference model: what a request must produce, from the request and the lock-drop plan.
  // k = -1: lock stays up; k = 0: lock low at acceptance; k >= 1: lock dropped right after pulse k ends.
  task automatic push_expect(input int sel, input int ud, input int steps, input int k, input int t);
    bit aborted;
    int pulses;
    aborted = (steps > 0) && ((k == 0) || ((k >= 1) && (k <= steps)));
    pulses  = aborted ? k : steps;
    for (int i = 0; i < pulses; i++)
      sb.push_back('{0, sel, ud, 0, 0, (i == 0) ? t + 2 : -1});
    sb.push_back('{1, 0, 0, int'(aborted), 0, ((steps == 0) || (k == 0)) ? t + 1 : -1});
  endtask

  // PLL model: phasedone falls a couple of cycles after a strobe rises and comes back later.
  initial begin
    int d, l;
    forever begin
      @(negedge clk);
      if (phasestep && !pd_off) begin
        pll_idle = 1'b0;
        d = PULSE + int'($urandom_range(0, 1));
        l = int'($urandom_range(1, 4));
        repeat (d) @(negedge clk);
        pll_phasedone = 1'b0;
        repeat (l) @(negedge clk);
        pll_phasedone = 1'b1;
        pll_idle = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a strobe completes or done pulses.
  initial begin
    bit ps_prev, dn_prev;
    int plen, psel, pud, prise;
    exp_t e;
    ps_prev = 0; dn_prev = 0; plen = 0; psel = 0; pud = 0; prise = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("busy_vs_ready", busy, !rif.req_ready);
        if (phasestep) begin
          if (!ps_prev) begin
            plen = 1; psel = phasecountersel; pud = phaseupdown; prise = cyc;
          end else begin
            plen++;
            check("sel_stable", phasecountersel, psel);
            check("ud_stable", phaseupdown, pud);
          end
        end else if (ps_prev) begin
          if (sb.size() == 0) fail_now("unexpected_step");
          else begin
            e = sb.pop_front();
            check("event_is_step", 0, e.kind);
            check("step_sel", psel, e.sel);
            check("step_ud", pud, e.ud);
            check("step_len", plen, PULSE);
            if (e.cyc >= 0) check("step_rise_cyc", prise, e.cyc);
          end
        end
        if (done) begin
          if (dn_prev) fail_now("done_longer_than_1");
          else if (sb.size() == 0) fail_now("unexpected_done");
          else begin
            e = sb.pop_front();
            check("event_is_done", 1, e.kind);
            check("done_err", err, e.err);
`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
            check("done_timeout_err", timeout_err, e.tmo);
`endif
            if (e.cyc >= 0) check("done_cyc", cyc, e.cyc);
          end
        end
        ps_prev = phasestep;
        dn_prev = done;
      end else begin
        ps_prev = 0;
        dn_prev = 0;
      end
    end
  end

  // One request: optional idle gap, accept, then ride out the busy phase (valid held if b2b).
  task automatic run_req(input int sel, input int ud, input int steps, input int k,
                         input int b2b, input int gap, input int tmo_case);
    int  g, wd, t, falls;
    bit  got, seen, prev_ps;
    g = gap; got = 0; wd = 0; t = 0;
    while (!got && !abort_run) begin
      @(negedge clk);
      rif.req_cntsel = 3'($urandom);
      rif.req_updown = 1'($urandom);
      rif.req_steps  = 8'($urandom);
      if (g > 0) begin
        rif.req_valid = 1'b0;
        g--;
      end else if (rif.req_ready && pll_idle) begin
        rif.req_cntsel = 3'(sel);
        rif.req_updown = 1'(ud);
        rif.req_steps  = 8'(steps);
        rif.req_valid  = 1'b1;
        pll_locked     = (k == 0) ? 1'b0 : 1'b1;
        t   = cyc;
        got = 1;
        if (tmo_case != 0) begin
          sb.push_back('{0, sel, ud, 0, 0, t + 2});
          sb.push_back('{1, 0, 0, 1, 1, t + 2 + PULSE + TMO});
        end else begin
          push_expect(sel, ud, steps, k, t);
        end
      end else begin
        rif.req_valid = 1'b0;
      end
      if (++wd > 300) begin fail_now("accept_timeout"); abort_run = 1; end
    end
    seen = 0; falls = 0; prev_ps = 0; wd = 0;
    while (got && !seen && !abort_run) begin
      @(negedge clk);
      rif.req_valid  = 1'(b2b);
      rif.req_cntsel = 3'($urandom);
      rif.req_updown = 1'($urandom);
      rif.req_steps  = 8'($urandom);
      if (prev_ps && !phasestep) begin
        falls++;
        if ((k > 0) && (falls == k)) pll_locked = 1'b0;
      end
      prev_ps = phasestep;
      if (done) begin
        seen = 1;
        pll_locked = 1'b1;
      end
      if (++wd > 1000) begin fail_now("done_timeout"); abort_run = 1; end
    end
  endtask

  // Bounded wait for a condition sampled on negedges.
  task automatic wait_for(input int which, input string nm);
    int wd;
    wd = 0;
    forever begin
      @(negedge clk);
      if ((which == 0) && rif.req_ready && pll_idle) break;
      if ((which == 1) && done) break;
      if ((which == 2) && phasestep) break;
      if (++wd > 500) begin fail_now(nm); break; end
    end
  endtask

  int t_sel [4] = '{2, 5, 4, 6};
  int t_ud  [4] = '{1, 0, 1, 0};
  int t_st  [4] = '{3, 0, 5, 2};
  int t_k   [4] = '{-1, -1, 2, -1};
  int t_b2b [4] = '{0, 0, 1, 1};

  initial begin
    int sel, ud, steps, k, b2b, gap, r;
    bit prev_b2b;
    rif.req_valid = 1'b0;
    rif.req_cntsel = '0;
    rif.req_updown = 1'b0;
    rif.req_steps = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", rif.req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_phasestep", phasestep, 0);
    check("rst_cntsel", phasecountersel, 0);
    check("rst_updown", phaseupdown, 0);
`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
    check("rst_timeout_err", timeout_err, 0);
`endif
    reset = 1'b0;
    mon_en = 1'b1;
    prev_b2b = 0;

    for (int n = 0; n < NREQ && !abort_run; n++) begin
      if (n < 4) begin
        sel = t_sel[n]; ud = t_ud[n]; steps = t_st[n]; k = t_k[n]; b2b = t_b2b[n];
      end else begin
        sel   = int'($urandom_range(0, 6));
        ud    = int'($urandom_range(0, 1));
        steps = int'($urandom_range(0, 5));
        b2b   = int'($urandom_range(0, 1));
        r     = int'($urandom_range(0, 9));
        k     = (r < 6) ? -1 : (r < 7) ? 0 : int'($urandom_range(1, (steps > 0) ? steps : 1));
      end
      gap = prev_b2b ? 0 : int'($urandom_range(0, 2));
      run_req(sel, ud, steps, k, b2b, gap, 0);
      prev_b2b = (b2b != 0);
    end

`ifdef CYCLONEIIILS_PLL_PHASE_TIMEOUT_EN
    if (!abort_run) begin
      wait_for(0, "tmo_idle_timeout");
      pd_off = 1'b1;
      run_req(int'(CSEL_C1), 1, 2, -1, 0, 0, 1);
      pd_off = 1'b0;
    end
`endif

    @(negedge clk);
    rif.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    mon_en = 1'b0;

    // err is sticky in IDLE and cleared by reset.
    wait_for(0, "rst1_idle_timeout");
    rif.req_cntsel = 3'd3; rif.req_updown = 1'b1; rif.req_steps = 8'd3;
    rif.req_valid = 1'b1; pll_locked = 1'b0;
    @(negedge clk);
    rif.req_valid = 1'b0;
    if (!done) wait_for(1, "rst1_done_timeout");
    check("abort_err", err, 1);
    @(negedge clk);
    pll_locked = 1'b1;
    check("err_sticky_idle", err, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("err_after_reset", err, 0);
    check("ready_after_reset", rif.req_ready, 1);

    // Reset while the strobe is high.
    wait_for(0, "rst2_idle_timeout");
    rif.req_cntsel = 3'd6; rif.req_updown = 1'b0; rif.req_steps = 8'd4;
    rif.req_valid = 1'b1;
    @(negedge clk);
    rif.req_valid = 1'b0;
    wait_for(2, "rst2_step_timeout");
    reset = 1'b1;
    @(negedge clk);
    check("midstep_rst_phasestep", phasestep, 0);
    check("midstep_rst_busy", busy, 0);
    check("midstep_rst_ready", rif.req_ready, 1);
    check("midstep_rst_err", err, 0);
    check("midstep_rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog (cycle %0d)", cyc);
    $fatal(1, "simulation watchdog expired");
  end

endmodule
